// File: rtl/axi_address_decoder_ordered.sv
// AR/AW address decoder for one target-side slave port.
// Region decode with fixed priority, same-target ordering, outstanding limit and DECERR burst generator.

module axi_addr_port_match #(
   parameter int ADDR_WIDTH = 32,
   parameter int N_REGION   = 4
) (
   input  logic [ADDR_WIDTH-1:0]               addr,
   input  logic [N_REGION-1:0][ADDR_WIDTH-1:0] start_addr,
   input  logic [N_REGION-1:0][ADDR_WIDTH-1:0] end_addr,
   input  logic [N_REGION-1:0]                 enable,
   input  logic                                connected,
   output logic                                hit
);
   logic any_region;

   always_comb begin
      any_region = 1'b0;
      for (int r = 0; r < N_REGION; r++)
         if (enable[r] && (addr >= start_addr[r]) && (addr <= end_addr[r]))
            any_region = 1'b1;
   end

   assign hit = any_region & connected;
endmodule

module axi_address_decoder_ordered #(
   parameter int ADDR_WIDTH      = 32,
   parameter int N_INIT_PORT     = 8,
   parameter int N_REGION        = 4,
   parameter int LEN_WIDTH       = 8,
   parameter int MAX_OUTSTANDING = 8,
   parameter int CNT_WIDTH       = $clog2(MAX_OUTSTANDING+1)
) (
   input  logic                                                  clk,
   input  logic                                                  rst_n,
   input  logic                                                  axvalid_i,
   input  logic [ADDR_WIDTH-1:0]                                 axaddr_i,
   input  logic [LEN_WIDTH-1:0]                                  axlen_i,
   output logic                                                  axready_o,
   output logic [N_INIT_PORT-1:0]                                axvalid_o,
   input  logic [N_INIT_PORT-1:0]                                axready_i,
   input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0]  START_ADDR_i,
   input  logic [N_REGION-1:0][N_INIT_PORT-1:0][ADDR_WIDTH-1:0]  END_ADDR_i,
   input  logic [N_REGION-1:0][N_INIT_PORT-1:0]                  enable_region_i,
   input  logic [N_INIT_PORT-1:0]                                connectivity_map_i,
   input  logic                                                  rsp_done_i,
   output logic                                                  err_valid_o,
   output logic                                                  err_last_o,
   input  logic                                                  err_ready_i,
   output logic [CNT_WIDTH-1:0]                                  outstanding_o
);
   localparam int IDX_W = (N_INIT_PORT > 1) ? $clog2(N_INIT_PORT) : 1;

   typedef enum logic [1:0] {OPERATIVE, DRAIN, ERR_RESP} state_t;

   state_t                 state_q, state_d;
   logic [CNT_WIDTH-1:0]   cnt_q;
   logic [IDX_W-1:0]       last_q;
   logic [LEN_WIDTH-1:0]   len_q, beat_q;

   logic [N_INIT_PORT-1:0] hit;
   logic                   hit_any;
   logic [IDX_W-1:0]       tgt;
   logic                   stall;
   logic [N_INIT_PORT-1:0] fwd_valid;
   logic                   fwd_ready;
   logic                   acc_hs;
   logic                   err_acc;
   logic                   err_hs;

   // Regions arrive region-major; regroup them per port for the matchers.
   for (genvar p = 0; p < N_INIT_PORT; p++) begin : g_port
      logic [N_REGION-1:0][ADDR_WIDTH-1:0] st, ed;
      logic [N_REGION-1:0]                 en;
      for (genvar r = 0; r < N_REGION; r++) begin : g_reg
         assign st[r] = START_ADDR_i[r][p];
         assign ed[r] = END_ADDR_i[r][p];
         assign en[r] = enable_region_i[r][p];
      end
      axi_addr_port_match #(
         .ADDR_WIDTH (ADDR_WIDTH),
         .N_REGION   (N_REGION)
      ) u_match (
         .addr       (axaddr_i),
         .start_addr (st),
         .end_addr   (ed),
         .enable     (en),
         .connected  (connectivity_map_i[p]),
         .hit        (hit[p])
      );
   end

   // Lowest index wins on overlap: scan downward so the last assignment is the lowest hit.
   always_comb begin
      tgt = '0;
      for (int p = N_INIT_PORT-1; p >= 0; p--)
         if (hit[p]) tgt = IDX_W'(p);
   end

   assign hit_any = |hit;
   assign stall   = (cnt_q == CNT_WIDTH'(MAX_OUTSTANDING)) ||
                    ((cnt_q != '0) && (tgt != last_q));
   assign err_hs  = (state_q == ERR_RESP) && err_ready_i;

   always_comb begin
      state_d   = state_q;
      fwd_valid = '0;
      fwd_ready = 1'b0;
      acc_hs    = 1'b0;
      err_acc   = 1'b0;
      case (state_q)
         OPERATIVE: begin
            if (hit_any) begin
               if (!stall) begin
                  fwd_valid[tgt] = axvalid_i;
                  fwd_ready      = axready_i[tgt];
                  acc_hs         = axvalid_i && axready_i[tgt];
               end
            end else if (axvalid_i) begin
               fwd_ready = 1'b1;
               err_acc   = 1'b1;
               state_d   = (cnt_q == '0) ? ERR_RESP : DRAIN;
            end
         end
         DRAIN: begin
            if (cnt_q == '0) state_d = ERR_RESP;
         end
         ERR_RESP: begin
            if (err_hs && (beat_q == len_q)) state_d = OPERATIVE;
         end
         default: state_d = OPERATIVE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= OPERATIVE;
         cnt_q   <= '0;
         last_q  <= '0;
         len_q   <= '0;
         beat_q  <= '0;
      end else begin
         state_q <= state_d;
         if (acc_hs) last_q <= tgt;
         // Coincident accept and completion cancel; a lone completion at zero is ignored.
         if (acc_hs && !rsp_done_i)
            cnt_q <= cnt_q + 1'b1;
         else if (!acc_hs && rsp_done_i && (cnt_q != '0))
            cnt_q <= cnt_q - 1'b1;
         if (err_acc) begin
            len_q  <= axlen_i;
            beat_q <= '0;
         end else if (err_hs) begin
            beat_q <= (beat_q == len_q) ? '0 : beat_q + 1'b1;
         end
      end
   end

   // Passthrough paths are gated so reset forces them low immediately.
   assign axvalid_o     = fwd_valid & {N_INIT_PORT{rst_n}};
   assign axready_o     = fwd_ready & rst_n;
   assign err_valid_o   = (state_q == ERR_RESP);
   assign err_last_o    = (state_q == ERR_RESP) && (beat_q == len_q);
   assign outstanding_o = cnt_q;
endmodule

// File: tb/tb_axi_address_decoder_ordered.sv
// Directed scenarios plus randomized traffic against a transaction-level reference model.
module tb_axi_address_decoder_ordered;
   localparam int AW   = 32;
   localparam int NP   = 8;
   localparam int NR   = 4;
   localparam int LW   = 8;
   localparam int MAXO = 8;
   localparam int CW   = $clog2(MAXO+1);

   logic                         clk = 1'b0;
   logic                         rst_n;
   logic                         axvalid_i;
   logic [AW-1:0]                axaddr_i;
   logic [LW-1:0]                axlen_i;
   logic                         axready_o;
   logic [NP-1:0]                axvalid_o;
   logic [NP-1:0]                axready_i;
   logic [NR-1:0][NP-1:0][AW-1:0] start_a, end_a;
   logic [NR-1:0][NP-1:0]        en_a;
   logic [NP-1:0]                conn;
   logic                         rsp_done_i;
   logic                         err_valid_o, err_last_o, err_ready_i;
   logic [CW-1:0]                outstanding_o;

   int checks = 0;
   int failures = 0;

   // reference model: 0 = accepting, 1 = waiting for in-flight to finish, 2 = sending error beats
   int m_mode, m_cnt, m_last, m_len, m_beat;

   axi_address_decoder_ordered #(
      .ADDR_WIDTH(AW), .N_INIT_PORT(NP), .N_REGION(NR), .LEN_WIDTH(LW), .MAX_OUTSTANDING(MAXO)
   ) dut (
      .clk(clk), .rst_n(rst_n), .axvalid_i(axvalid_i), .axaddr_i(axaddr_i), .axlen_i(axlen_i),
      .axready_o(axready_o), .axvalid_o(axvalid_o), .axready_i(axready_i),
      .START_ADDR_i(start_a), .END_ADDR_i(end_a), .enable_region_i(en_a),
      .connectivity_map_i(conn), .rsp_done_i(rsp_done_i), .err_valid_o(err_valid_o),
      .err_last_o(err_last_o), .err_ready_i(err_ready_i), .outstanding_o(outstanding_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // first connected port (ascending) with any enabled region containing the address, else -1
   function automatic int decode(input logic [AW-1:0] a);
      for (int p = 0; p < NP; p++) begin
         if (!conn[p]) continue;
         for (int r = 0; r < NR; r++)
            if (en_a[r][p] && a >= start_a[r][p] && a <= end_a[r][p]) return p;
      end
      return -1;
   endfunction

   task automatic map(input int r, input int p, input logic [AW-1:0] lo, input logic [AW-1:0] hi);
      start_a[r][p] = lo;
      end_a[r][p]   = hi;
      en_a[r][p]    = 1'b1;
   endtask

   task automatic drive(input logic v, input logic [AW-1:0] a, input logic [LW-1:0] l,
                        input logic [NP-1:0] rdy, input logic done, input logic erdy);
      axvalid_i = v; axaddr_i = a; axlen_i = l; axready_i = rdy;
      rsp_done_i = done; err_ready_i = erdy;
   endtask

   // Checks all outputs against the model for the current cycle, then advances one clock.
   task automatic step(input string tag);
      int t;
      bit blk, acc;
      logic [NP-1:0] ev;
      logic er, eev, eel;
      #1;
      ev = '0; er = 1'b0; eev = 1'b0; eel = 1'b0; acc = 1'b0; t = -1;
      if (!rst_n) begin
         m_mode = 0; m_cnt = 0; m_last = 0; m_beat = 0;
      end else begin
         case (m_mode)
            0: begin
               t = decode(axaddr_i);
               if (t >= 0) begin
                  blk = (m_cnt == MAXO) || (m_cnt != 0 && t != m_last);
                  if (!blk) begin
                     ev[t] = axvalid_i;
                     er    = axready_i[t];
                     acc   = axvalid_i && axready_i[t];
                  end
               end else if (axvalid_i) begin
                  er = 1'b1;
                  m_mode = (m_cnt == 0) ? 2 : 1;
                  m_len = int'(axlen_i);
                  m_beat = 0;
               end
            end
            1: if (m_cnt == 0) m_mode = 2;
            default: begin
               eev = 1'b1;
               eel = (m_beat == m_len);
               if (err_ready_i) begin
                  if (eel) begin m_mode = 0; m_beat = 0; end
                  else m_beat++;
               end
            end
         endcase
      end
      chk({tag, ".axvalid_o"},     64'(axvalid_o),     64'(ev));
      chk({tag, ".axready_o"},     64'(axready_o),     64'(er));
      chk({tag, ".err_valid_o"},   64'(err_valid_o),   64'(eev));
      chk({tag, ".err_last_o"},    64'(err_last_o),    64'(eel));
      chk({tag, ".outstanding_o"}, 64'(outstanding_o), 64'(m_cnt));
      if (rst_n) begin
         if (acc) m_last = t;
         if (acc && !rsp_done_i) m_cnt++;
         else if (!acc && rsp_done_i && m_cnt > 0) m_cnt--;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   logic [AW-1:0] pool [10];

   initial begin
      rst_n = 1'b0;
      start_a = '0; end_a = '0; en_a = '0;
      conn = 8'hBF;                          // port 6 unreachable
      map(0, 2, 32'h1000, 32'h1FFF);
      map(0, 1, 32'h2000, 32'h2FFF);
      map(1, 3, 32'h2000, 32'h3FFF);
      map(3, 4, 32'h3000, 32'h4FFF);         // overlaps port 3 on 0x3000-0x3FFF
      map(0, 5, 32'h5000, 32'h5FFF);
      map(2, 0, 32'h8000, 32'h8FFF);
      map(0, 6, 32'h6000, 32'h6FFF);
      start_a[1][7] = 32'h7000; end_a[1][7] = 32'h7FFF;   // region left disabled
      m_mode = 0; m_cnt = 0; m_last = 0; m_len = 0; m_beat = 0;

      // reset holds every output low even with a live mapped request
      drive(1'b1, 32'h1800, 8'd0, 8'hFF, 1'b0, 1'b1);
      step("reset");
      rst_n = 1'b1;

      // T1: zero-latency forward to port 2
      drive(1'b1, 32'h1800, 8'd0, 8'h04, 1'b0, 1'b0);
      #1 chk("t1.fwd", 64'(axvalid_o), 64'h04);
      step("t1");
      drive(1'b0, 32'h1800, 8'd0, 8'h00, 1'b1, 1'b0);
      #1 chk("t1.cnt", 64'(outstanding_o), 64'd1);
      step("t1_done");

      // T2: overlapping ports 1 and 3, lowest wins
      drive(1'b1, 32'h2000, 8'd0, 8'h00, 1'b0, 1'b0);
      #1 chk("t2.prio", 64'(axvalid_o), 64'h02);
      step("t2");

      // T3: ordering stall until port 2 traffic drains
      drive(1'b1, 32'h1800, 8'd0, 8'h04, 1'b0, 1'b0);
      step("t3_a0");
      step("t3_a1");
      drive(1'b1, 32'h5000, 8'd0, 8'h20, 1'b0, 1'b0);
      #1 chk("t3.stall", 64'(axvalid_o), 64'h00);
      step("t3_stall");
      rsp_done_i = 1'b1;
      step("t3_d0");
      step("t3_d1");
      rsp_done_i = 1'b0;
      #1 chk("t3.release", 64'(axvalid_o), 64'h20);
      step("t3_go");

      // T4: unmapped burst with one in flight -> drain, then 4 DECERR beats
      drive(1'b1, 32'hF000_0000, 8'd3, 8'hFF, 1'b0, 1'b0);
      #1 chk("t4.err_accept", 64'(axready_o), 64'd1);
      step("t4_acc");
      drive(1'b1, 32'h5000, 8'd0, 8'hFF, 1'b0, 1'b0);
      step("t4_drain");
      rsp_done_i = 1'b1;
      step("t4_done");
      rsp_done_i = 1'b0;
      step("t4_zero");
      for (int i = 0; i < 8; i++) begin
         err_ready_i = i[0];
         step($sformatf("t4_beat%0d", i));
      end
      axvalid_i = 1'b0; err_ready_i = 1'b0;
      step("t4_back");

      // T5: fill to the limit on port 0
      drive(1'b1, 32'h8000, 8'd0, 8'h01, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step($sformatf("t5_fill%0d", i));
      #1 chk("t5.full_ready", 64'(axready_o), 64'd0);
      chk("t5.full_cnt", 64'(outstanding_o), 64'd8);
      step("t5_full");
      rsp_done_i = 1'b1;
      step("t5_free");
      step("t5_coincident");
      #1 chk("t5.coincident_cnt", 64'(outstanding_o), 64'd7);
      rsp_done_i = 1'b0;
      step("t5_refill");
      axvalid_i = 1'b0; rsp_done_i = 1'b1;
      for (int i = 0; i < 9; i++) step($sformatf("t5_drain%0d", i));
      rsp_done_i = 1'b0;

      // T6: asynchronous reset in the middle of an error burst
      drive(1'b1, 32'h6000, 8'd3, 8'hFF, 1'b0, 1'b0);
      step("t6_acc");
      axvalid_i = 1'b0; err_ready_i = 1'b1;
      step("t6_b0");
      step("t6_b1");
      err_ready_i = 1'b0;
      #2 rst_n = 1'b0;
      #1 chk("t6.rst_err_valid", 64'(err_valid_o), 64'd0);
      chk("t6.rst_err_last", 64'(err_last_o), 64'd0);
      step("t6_rst");
      rst_n = 1'b1;
      drive(1'b1, 32'h5000, 8'd0, 8'h20, 1'b0, 1'b0);
      #1 chk("t6.after", 64'(axvalid_o), 64'h20);
      step("t6_after");

      // randomized traffic
      pool = '{32'h1800, 32'h2000, 32'h2FFF, 32'h3800, 32'h4800, 32'h5000,
               32'h6000, 32'h7000, 32'h8FFF, 32'hF000_0000};
      for (int i = 0; i < 400; i++) begin
         drive($urandom_range(0, 3) != 0, pool[$urandom_range(0, 9)], LW'($urandom_range(0, 3)),
               NP'($urandom), $urandom_range(0, 3) == 0, 1'($urandom));
         step($sformatf("rnd%0d", i));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
